// File: rtl/reaction_pkg.sv
// -----------------------------------------------------------------------------
// reaction_pkg
//
// Shared definitions for the reaction timer:
//   - state_e       : FSM state encoding (3 bits)
//   - DIGIT_W       : width of one BCD digit
//   - NUM_DIGITS    : number of display digits
//   - BCD_MAX       : saturation value of the 4-digit BCD count (9999)
//   - bin_to_bcd4() : elaboration-time conversion of a binary limit to BCD
// -----------------------------------------------------------------------------
package reaction_pkg;

  localparam int          DIGIT_W    = 4;
  localparam int          NUM_DIGITS = 4;
  localparam int          BCD_W      = DIGIT_W * NUM_DIGITS;
  localparam logic [15:0] BCD_MAX    = 16'h9999;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_TIMING = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

  // Converts a binary value (0..9999) to four packed BCD digits. Used only
  // on parameters, so it folds away at elaboration.
  function automatic logic [15:0] bin_to_bcd4(input int unsigned value);
    logic [15:0] res;
    res[3:0]   = 4'(value % 10);
    res[7:4]   = 4'((value / 10) % 10);
    res[11:8]  = 4'((value / 100) % 10);
    res[15:12] = 4'((value / 1000) % 10);
    return res;
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// -----------------------------------------------------------------------------
// bcd_counter4
//
// Four-digit cascaded BCD incrementer with synchronous clear. The count
// saturates at MAX_BCD: an increment request at the limit is ignored, and
// the owner of the counter decides what saturation means.
//
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous active-high reset (count -> 0)
//   clr     in   synchronous clear (wins over inc)
//   inc     in   add one to the count, decimal ripple carry
//   bcd     out  {thousands, hundreds, tens, ones}
//   at_max  out  count equals MAX_BCD
// -----------------------------------------------------------------------------
module bcd_counter4
  import reaction_pkg::*;
#(
  parameter logic [15:0] MAX_BCD = BCD_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] bcd,
  output logic        at_max
);

  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] bcd_d;
  logic             carry;

  assign at_max = (bcd_q == MAX_BCD);
  assign bcd    = bcd_q;

  // NOTE: every signal driven here gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    bcd_d = bcd_q;
    carry = 1'b0;
    if (clr) begin
      bcd_d = '0;
    end else if (inc && !at_max) begin
      // Ripple from the ones digit upward: a digit at 9 wraps to 0 and
      // passes the carry on, otherwise it absorbs the carry.
      carry = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (carry) begin
          if (bcd_q[i*DIGIT_W +: DIGIT_W] == 4'd9) begin
            bcd_d[i*DIGIT_W +: DIGIT_W] = 4'd0;
          end else begin
            bcd_d[i*DIGIT_W +: DIGIT_W] = bcd_q[i*DIGIT_W +: DIGIT_W] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q <= '0;
    end else begin
      bcd_q <= bcd_d;
    end
  end

endmodule

// File: rtl/reaction_timer.sv
// -----------------------------------------------------------------------------
// reaction_timer
//
// Sits behind the pre-start countdown. A start pulse arms a round; the
// rising edge of the (asynchronous) countdown_done level starts a
// millisecond count; the next button press stops it. A press before the
// count starts is a false start; reaching 9999 ms without a press is a
// timeout. The count is kept in BCD for the 7-segment display path.
//
// Ports:
//   clk             in   system clock
//   rst             in   asynchronous active-high reset
//   start           in   1-cycle pulse, arms a new round from any state
//   countdown_done  in   level, asynchronous to clk, held high after countdown
//   btn             in   debounced button level, synchronous to clk
//   bcd             out  elapsed ms, {thousands, hundreds, tens, ones}
//   timing          out  measurement running
//   result_valid    out  round finished with a valid reaction time
//   false_start     out  round aborted by a press before go
//   timeout         out  round aborted by the 9999 ms limit
// -----------------------------------------------------------------------------
module reaction_timer
  import reaction_pkg::*;
#(
  parameter int TICKS_PER_MS = 100000,
  parameter int MAX_MS       = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        countdown_done,
  input  logic        btn,
  output logic [15:0] bcd,
  output logic        timing,
  output logic        result_valid,
  output logic        false_start,
  output logic        timeout
);

  localparam int PRESC_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_MS - 1);
  localparam logic [15:0]        MAX_BCD    = bin_to_bcd4(MAX_MS);

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic cd_meta_q;
  logic cd_sync_q;
  logic cd_prev_q;
  logic btn_q;
  logic go;
  logic press;

  // Two flops resolve metastability on the asynchronous countdown level; a
  // third holds the previous synchronized value for edge detection. Only a
  // low-to-high transition produces go, so a level that is already high when
  // a round is armed never starts the measurement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cd_meta_q <= 1'b0;
      cd_sync_q <= 1'b0;
      cd_prev_q <= 1'b0;
      btn_q     <= 1'b0;
    end else begin
      cd_meta_q <= countdown_done;
      cd_sync_q <= cd_meta_q;
      cd_prev_q <= cd_sync_q;
      btn_q     <= btn;
    end
  end

  assign go    = cd_sync_q & ~cd_prev_q;
  // btn is already synchronous; a button held through start shows no edge.
  assign press = btn & ~btn_q;

  // ---------------------------------------------------------------------------
  // FSM, prescaler and status flags
  // ---------------------------------------------------------------------------
  state_e             state_q;
  state_e             state_d;
  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_d;
  logic               false_start_q;
  logic               false_start_d;
  logic               timeout_q;
  logic               timeout_d;
  logic               ms_tick;
  logic               cnt_clr;
  logic               cnt_inc;
  logic               cnt_at_max;

  assign ms_tick = (state_q == ST_TIMING) && (presc_q == PRESC_LAST);

  always_comb begin
    state_d       = state_q;
    presc_d       = presc_q;
    false_start_d = false_start_q;
    timeout_d     = timeout_q;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;

    if (start) begin
      // A new round overrides whatever the current state is doing,
      // including a press in the same cycle.
      state_d       = ST_ARMED;
      presc_d       = '0;
      false_start_d = 1'b0;
      timeout_d     = 1'b0;
      cnt_clr       = 1'b1;
    end else begin
      case (state_q)
        ST_ARMED: begin
          // An early press beats a go arriving in the same cycle.
          if (press) begin
            state_d       = ST_FAULT;
            false_start_d = 1'b1;
          end else if (go) begin
            state_d = ST_TIMING;
            presc_d = '0;
            cnt_clr = 1'b1;
          end
        end

        ST_TIMING: begin
          if (press) begin
            // The press freezes the count; a tick in this same cycle is
            // dropped so the result never over-reports.
            state_d = ST_DONE;
          end else begin
            presc_d = ms_tick ? '0 : presc_q + 1'b1;
            if (ms_tick) begin
              if (cnt_at_max) begin
                state_d   = ST_FAULT;
                timeout_d = 1'b1;
              end else begin
                cnt_inc = 1'b1;
              end
            end
          end
        end

        // IDLE, DONE and FAULT hold everything until the next start.
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      presc_q       <= '0;
      false_start_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      false_start_q <= false_start_d;
      timeout_q     <= timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Millisecond counter
  // ---------------------------------------------------------------------------
  bcd_counter4 #(
    .MAX_BCD (MAX_BCD)
  ) u_bcd_counter4 (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .bcd    (bcd),
    .at_max (cnt_at_max)
  );

  // ---------------------------------------------------------------------------
  // Outputs: all decoded from registers
  // ---------------------------------------------------------------------------
  assign timing       = (state_q == ST_TIMING);
  assign result_valid = (state_q == ST_DONE);
  assign false_start  = false_start_q;
  assign timeout      = timeout_q;

endmodule
